sync_chan_arbiter: RTL and testbench

//  Shares one slow-path clock-crossing channel between N requesters in the clk domain.

---
 rtl/sync_chan_arbiter_pkg.sv | 18 +
 rtl/sync_chan_arbiter_if.sv | 34 +++
 rtl/sync_chan_arbiter_rr_pick.sv | 36 +++
 rtl/sync_chan_arbiter.sv | 147 ++++++++++++++
 tb/tb_sync_chan_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_chan_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_chan_pkg: shared FSM state codes and index-width helper.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_chan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chan_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_chan_arbiter_if: requester bus plus far-side 4-phase handshake.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sync_chan_arbiter_if
  import sync_chan_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) ();

  logic [N-1:0]             req;
  logic [N*W-1:0]           req_data;
  logic [N-1:0]             grant;
  logic                     busy;
  logic [W-1:0]             xfer_data;
  logic [id_width(N)-1:0]   xfer_id;
  logic                     xfer_req;
  logic                     xfer_ack;
  logic                     err_timeout;

  modport master (
    output req, req_data, xfer_ack,
    input  grant, busy, xfer_data, xfer_id, xfer_req, err_timeout
  );

  modport slave (
    input  req, req_data, xfer_ack,
    output grant, busy, xfer_data, xfer_id, xfer_req, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sync_chan_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first set bit from ptr up.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick
  import sync_chan_pkg::*;
#(
  parameter int N = 4
) (
  input  wire [N-1:0]             req,
  input  wire [id_width(N)-1:0]   ptr,
  output logic                    found,
  output logic [id_width(N)-1:0]  idx
);

  localparam int c_IDW = id_width(N);

  // Scan from the farthest position back to ptr so the nearest hit wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = c_IDW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_chan_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_chan_arbiter: round-robin share of one 4-phase CDC channel.         |
// | Optional ack-wait abort: define SYNC_ARB_TIMEOUT_EN.      Rev 1.0        |
// +--------------------------------------------------------------------------+
module sync_chan_arbiter
  import sync_chan_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int SETUP   = 4,
  parameter int TIMEOUT = 1023
) (
  input wire                 clk,
  input wire                 rst_n,
  sync_chan_arbiter_if.slave bus
);

  localparam int                 c_IDW       = id_width(N);
  localparam int                 c_SCW       = $clog2(SETUP + 1);
  localparam logic [c_IDW-1:0]   c_LAST_ID   = c_IDW'(N - 1);
  localparam logic [c_SCW-1:0]   c_SETUP_END = c_SCW'(SETUP);

  if (N < 2 || SETUP < 1 || TIMEOUT < 1) begin : g_param_check
    $error("sync_chan_arbiter: requires N >= 2, SETUP >= 1, TIMEOUT >= 1");
  end

  logic [1:0]       r_state;
  logic [c_IDW-1:0] r_rr_ptr;
  logic [c_SCW-1:0] r_setup_cnt;
  logic [N-1:0]     r_grant;
  logic             r_busy;
  logic [W-1:0]     r_xfer_data;
  logic [c_IDW-1:0] r_xfer_id;
  logic             r_xfer_req;
  logic             w_found;
  logic [c_IDW-1:0] w_idx;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (bus.req),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam int               c_TOW     = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  // Abort on the edge where the wait count would reach TIMEOUT.
  localparam logic [c_TOW-1:0] c_TO_LAST = c_TOW'(TIMEOUT - 1);
  logic [c_TOW-1:0] r_to_cnt;
  logic             r_err_timeout;
  logic             w_to_hit;
  assign w_to_hit        = (r_to_cnt == c_TO_LAST);
  assign bus.err_timeout = r_err_timeout;
`else
  assign bus.err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_setup_cnt   <= '0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_xfer_data   <= '0;
      r_xfer_id     <= '0;
      r_xfer_req    <= 1'b0;
`ifdef SYNC_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
`ifdef SYNC_ARB_TIMEOUT_EN
      r_err_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // A stale ack from the far side must clear before a new capture.
          if (w_found && !bus.xfer_ack) begin
            r_xfer_data    <= bus.req_data[w_idx*W +: W];
            r_xfer_id      <= w_idx;
            r_grant[w_idx] <= 1'b1;
            r_rr_ptr       <= (w_idx == c_LAST_ID) ? '0 : w_idx + c_IDW'(1);
            r_busy         <= 1'b1;
            r_setup_cnt    <= '0;
            r_state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_setup_cnt == c_SETUP_END) begin
            r_xfer_req <= 1'b1;
            r_state    <= ST_REQ;
`ifdef SYNC_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end else begin
            r_setup_cnt <= r_setup_cnt + c_SCW'(1);
          end
        end
        ST_REQ: begin
          if (bus.xfer_ack) begin
            r_xfer_req <= 1'b0;
            r_state    <= ST_DROP;
`ifdef SYNC_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
          end else if (w_to_hit) begin
            r_xfer_req    <= 1'b0;
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + c_TOW'(1);
`endif
          end
        end
        ST_DROP: begin
          if (!bus.xfer_ack) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`ifdef SYNC_ARB_TIMEOUT_EN
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + c_TOW'(1);
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.xfer_data = r_xfer_data;
  assign bus.xfer_id   = r_xfer_id;
  assign bus.xfer_req  = r_xfer_req;

endmodule
`default_nettype wire

// File: tb/tb_sync_chan_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_chan_arbiter: directed stimulus, cycle model and literal checks. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_chan_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int SETUP   = 4;
  localparam int TIMEOUT = 16;
  localparam int ACK_DLY = 3;
`ifdef SYNC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ack_auto;
  logic ack_manual;
  logic ack_loop;
  int   n_checks;
  int   n_fail;

  sync_chan_arbiter_if #(.N(N), .W(W)) bus ();

  sync_chan_arbiter #(.N(N), .W(W), .SETUP(SETUP), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.xfer_ack = ack_auto ? ack_loop : ack_manual;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Far-side receiver: mirror xfer_req onto ack after ACK_DLY cycles of disagreement.
  initial begin
    int dly;
    dly = 0;
    ack_loop = 1'b0;
    forever begin
      @(negedge clk);
      if (!ack_auto) begin
        ack_loop = ack_manual;
        dly = 0;
      end else if (ack_loop != bus.xfer_req) begin
        dly++;
        if (dly >= ACK_DLY) begin
          ack_loop = bus.xfer_req;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // Behavioural model: a transfer is "captured", then the request rises SETUP+1
  // edges later, falls on ack (or after TIMEOUT edges), and the channel frees on ack low.
  int         m_ptr, m_age, m_wait, m_win;
  bit         m_busy, m_xreq, m_drop, m_err;
  logic [3:0]  m_grant;
  logic [31:0] m_data;
  logic [1:0]  m_id;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_age = 0; m_wait = 0; m_busy = 0; m_xreq = 0; m_drop = 0;
      m_err = 0; m_grant = '0; m_data = '0; m_id = '0;
    end else begin
      m_grant = '0;
      m_err   = 0;
      if (!m_busy) begin
        if (bus.req != '0 && !bus.xfer_ack) begin
          m_win = -1;
          for (int k = 0; k < N; k++)
            if (m_win < 0 && bus.req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
          m_data  = bus.req_data[m_win*W +: W];
          m_id    = 2'(m_win);
          m_grant = 4'(1 << m_win);
          m_ptr   = (m_win + 1) % N;
          m_busy  = 1; m_age = 0; m_drop = 0; m_xreq = 0;
        end
      end else if (m_xreq) begin
        m_wait = m_wait + 1;
        if (bus.xfer_ack) begin
          m_xreq = 0; m_drop = 1; m_wait = 0;
        end else if (TO_EN && m_wait == TIMEOUT) begin
          m_xreq = 0; m_busy = 0; m_err = 1;
        end
      end else if (m_drop) begin
        m_wait = m_wait + 1;
        if (!bus.xfer_ack) begin
          m_drop = 0; m_busy = 0;
        end else if (TO_EN && m_wait == TIMEOUT) begin
          m_drop = 0; m_busy = 0; m_err = 1;
        end
      end else begin
        m_age = m_age + 1;
        if (m_age == SETUP + 1) begin
          m_xreq = 1; m_wait = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("grant",       bus.grant,       m_grant);
      check("busy",        bus.busy,        m_busy);
      check("xfer_data",   bus.xfer_data,   m_data);
      check("xfer_id",     bus.xfer_id,     m_id);
      check("xfer_req",    bus.xfer_req,    m_xreq);
      check("err_timeout", bus.err_timeout, m_err);
    end
  end

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100 && bus.busy; c++) @(negedge clk);
    check(name, bus.busy, 0);
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    int k, got, gap;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; ack_auto = 1'b1; ack_manual = 1'b0;
    bus.req = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'hCAFE0000 + i;
    repeat (3) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_xfer_req", bus.xfer_req, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single requester, setup latency
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    check("t1_grant", bus.grant, 4'b0100);
    check("t1_id", bus.xfer_id, 2);
    check("t1_data", bus.xfer_data, 32'hCAFE0002);
    k = 1;
    while (!bus.xfer_req && k < 40) begin @(negedge clk); k++; end
    check("t1_setup_latency", k - 1, SETUP + 1);
    wait_idle("t1_idle");
    check("t1_data_persist", bus.xfer_data, 32'hCAFE0002);

    // 6: requester withdraws after grant
    bus.req = 4'b0010;
    bus.req_data[1*W +: W] = 32'h11110001;
    @(negedge clk);
    check("t6_grant", bus.grant, 4'b0010);
    @(negedge clk);
    bus.req = '0;
    bus.req_data[1*W +: W] = 32'hDEADBEEF;
    wait_idle("t6_idle");
    check("t6_data", bus.xfer_data, 32'h11110001);
    check("t6_id", bus.xfer_id, 1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: all requesting, fairness and one idle cycle between transfers
    bus.req = 4'b1111;
    got = 0; gap = 0;
    for (int c = 0; c < 300 && got < 5; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        check("t2_grant_seq", bus.grant, exp_seq[got]);
        if (got > 0) check("t2_idle_gap", gap, 1);
        got++; gap = 0;
        if (got == 5) bus.req = '0;
      end else if (!bus.busy) begin
        gap++;
      end
    end
    check("t2_count", got, 5);
    wait_idle("t2_idle");

    // 3: stale ack blocks capture
    ack_auto = 1'b0; ack_manual = 1'b1;
    bus.req = 4'b0001;
    repeat (4) begin
      @(negedge clk);
      check("t3_blocked_grant", bus.grant, 0);
      check("t3_blocked_busy", bus.busy, 0);
    end
    ack_manual = 1'b0;
    @(negedge clk);
    check("t3_grant", bus.grant, 4'b0001);
    bus.req = '0;
    ack_auto = 1'b1;
    wait_idle("t3_idle");

    // 4: asynchronous reset mid-handshake
    ack_auto = 1'b0; ack_manual = 1'b0;
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    for (int c = 0; c < 20 && !bus.xfer_req; c++) @(negedge clk);
    check("t4_in_req", bus.xfer_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_grant", bus.grant, 0);
    check("t4_async_busy", bus.busy, 0);
    check("t4_async_data", bus.xfer_data, 0);
    check("t4_async_id", bus.xfer_id, 0);
    check("t4_async_req", bus.xfer_req, 0);
    check("t4_async_err", bus.err_timeout, 0);
    bus.req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_grant_after_rst", bus.grant, 4'b0001);
    bus.req = '0;
    ack_auto = 1'b1;
    wait_idle("t4_idle");

`ifdef SYNC_ARB_TIMEOUT_EN
    // 5: ack never rises
    ack_auto = 1'b0; ack_manual = 1'b0;
    bus.req = 4'b0010;
    @(negedge clk);
    check("t5_grant", bus.grant, 4'b0010);
    bus.req = '0;
    for (int c = 0; c < 20 && !bus.xfer_req; c++) @(negedge clk);
    k = 0;
    while (bus.xfer_req && k < 40) begin @(negedge clk); k++; end
    check("t5_req_width", k, TIMEOUT);
    check("t5_err_pulse", bus.err_timeout, 1);
    bus.req = 4'b0011;
    @(negedge clk);
    check("t5_err_clear", bus.err_timeout, 0);
    check("t5_next_grant", bus.grant, 4'b0001);
    bus.req = '0;
    ack_auto = 1'b1;
    wait_idle("t5_idle");
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
